fc_mac_scheduler: RTL and testbench
===================================

Name: fc_mac_scheduler

Overview:
- Shares one serial fully-connected MAC datapath between NUM_REQ cnn cores.
- Round-robin arbitration over core requests; the granted core's N_IN-element input vector is latched.
- Sequences one multiply-accumulate per cycle against programmable weights, adds the bias, and returns the result with a one-cycle valid to the granted core.
- Also owns the FC weight/bias configuration registers.

Parameters:
- NUM_REQ, 4, number of requesting cores
- N_IN, 9, elements per FC input vector
- DW, 32, signed element/weight/bias width
- ACC_W, 32, signed accumulator/result width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  NUM_REQ  per-core request, held until gnt
- req_data  in  NUM_REQ*N_IN*DW  flattened vectors; core k element i at bits [(k*N_IN+i)*DW +: DW]
- gnt  out  NUM_REQ  one-hot, one-cycle pulse; vector captured on that edge
- rsp_valid  out  NUM_REQ  one-hot, one-cycle result strobe
- rsp_data  out  ACC_W  result, valid with rsp_valid
- busy  out  1  high in MAC and DONE
- cfg_we  in  1  config write strobe
- cfg_addr  in  $clog2(N_IN+1)  0..N_IN-1 selects a weight; N_IN selects the bias
- cfg_wdata  in  DW  config data

Behaviour:
- Reset values:
  - gnt=0, rsp_valid=0, rsp_data=0, busy=0
  - state=IDLE, rr pointer=0 (core 0 has highest priority)
  - all weights=1, bias=0
- All outputs are registered.
- IDLE:
  - If any req bit is set, select the first set bit searching from ptr upward with wrap.
  - On that edge: gnt<=onehot(k), latch core k's vector, acc<=0, idx<=0, ptr<=(k+1) mod NUM_REQ, go to MAC.
  - No req: stay in IDLE.
- MAC:
  - Each edge: acc<=acc+x[idx]*w[idx], with a signed DW×DW product truncated/wrapped to ACC_W.
  - idx increments each edge; after the idx=N_IN-1 edge, go to DONE.
  - Takes exactly N_IN edges.
- DONE:
  - One edge: rsp_data<=acc+bias (wrapping), rsp_valid<=onehot(k), go to IDLE.
- Latency: rsp_valid rises N_IN+1 edges after the gnt edge.
- Back-to-back throughput: one request per N_IN+2 cycles.
- No new grant is issued while busy; the req vector is ignored until IDLE.
- Deasserting req before gnt is legal; that core is not served.
- Weights used are the values at the time of each MAC step. The vector is frozen at the gnt edge; later req_data changes do not affect the result.
- Config:
  - cfg_we in IDLE writes cfg_wdata at cfg_addr on that edge.
  - cfg_we while busy is dropped silently.
  - cfg_addr > N_IN is ignored.
  - A config write and a grant on the same IDLE edge: the write lands first-class; the new value is used by that job.
- rst mid-job: the job is aborted, no rsp_valid is issued, and all reset values above are restored, including weights and bias.

Optional Feature:
- Macro: FC_SAT_EN.
- Defined:
  - Every accumulate step and the bias add saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Each product is computed at full 2*DW width before saturation.
- Undefined: all arithmetic wraps modulo 2^ACC_W.

Decomposition:
- Package fc_pkg:
  - state enum {IDLE, MAC, DONE}
  - FC_N_IN=9
  - localparam FC_BIAS_ADDR=N_IN
  - a sat/wrap accumulate function
- One sub-module, fc_rr_arbiter: parameterised NUM_REQ, ptr-based round-robin, returning the one-hot grant and the next pointer.

Test Plan:
- Single request at default config:
  - Stimulus: after reset, core0 req with x=1..9.
  - Response: gnt[0] once; rsp_valid[0] 10 edges later; rsp_data=45; busy high for 10 cycles.
- Programmed config:
  - Stimulus: write w[i]=i (i=0..8) and bias=-5; core2 req with all x=2.
  - Response: rsp_data=67; rsp_valid[2] only.
- Round-robin fairness:
  - Stimulus: all four reqs held continuously.
  - Response: grant order 0,1,2,3,0; every rsp_valid index matches the preceding gnt; spacing is 11 cycles.
- Config write while busy:
  - Stimulus: bias write of 100 during a MAC step.
  - Response: result unchanged (45). The same write in IDLE makes the next result 145.
- Reset mid-job:
  - Stimulus: rst during MAC idx=4.
  - Response: no rsp_valid; busy=0 and weights=1 after the edge; the next req from cores 1 and 0 together grants core 0.
- Overflow:
  - Stimulus: x0=32'h7FFFFFFF, w0=2, other x=0.
  - Response: rsp_data=32'hFFFFFFFE when wrapping; 32'h7FFFFFFF with FC_SAT_EN defined.

Source files
------------

// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fc_pkg
// Purpose  : Shared types, constants and arithmetic helper for the FC MAC
//            scheduler: FSM state encoding, default vector length, bias
//            address and the saturating / wrapping accumulate step.
// Revision : 1.0 - initial release
// ============================================================================
package fc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } fc_state_t;

   localparam int FC_N_IN      = 9;
   localparam int FC_BIAS_ADDR = FC_N_IN;

   // One accumulate step on values sign-extended to 64 bits.
   // The sum is formed at 65 bits so it can never overflow internally, then
   // either clamped to the signed accw-bit range or wrapped modulo 2^accw.
   // Supports accw up to 64 and operands that fit in 64 signed bits.
   function automatic logic signed [63:0] fc_accum(
      input logic signed [63:0] a,
      input logic signed [63:0] b,
      input int                 accw,
      input bit                 sat
   );
      logic signed [64:0] s;
      logic signed [64:0] hi;
      logic signed [64:0] lo;
      s  = {a[63], a} + {b[63], b};
      hi = (65'sd1 <<< (accw - 1)) - 65'sd1;
      lo = -(65'sd1 <<< (accw - 1));
      if (sat) begin
         if (s > hi) begin
            s = hi;
         end else if (s < lo) begin
            s = lo;
         end
      end else begin
         // Keep the low accw bits and sign-extend them back out.
         s = (s <<< (65 - accw)) >>> (65 - accw);
      end
      return s[63:0];
   endfunction

endpackage : fc_pkg
`default_nettype wire

// File: rtl/fc_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fc_rr_arbiter
// Purpose  : Combinational pointer-based round-robin arbiter. The first set
//            request at or above i_ptr (wrapping) wins.
// Ports    : i_req      - request vector
//            i_ptr      - current highest-priority index
//            o_any      - at least one request present
//            o_gnt      - one-hot grant
//            o_sel      - binary index of the winner
//            o_next_ptr - index just above the winner (wrapping)
// Revision : 1.0 - initial release
// ============================================================================
module fc_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PW-1:0]      i_ptr,
   output logic               o_any,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [PW-1:0]      o_sel,
   output logic [PW-1:0]      o_next_ptr
);

   logic [PW-1:0] w_cand;

   // Scan offsets from farthest to nearest so the request closest to the
   // pointer is the last assignment and therefore wins.
   always_comb begin
      o_any      = 1'b0;
      o_gnt      = '0;
      o_sel      = '0;
      o_next_ptr = i_ptr;
      w_cand     = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         w_cand = PW'((int'(i_ptr) + off) % NUM_REQ);
         if (i_req[w_cand]) begin
            o_any      = 1'b1;
            o_sel      = w_cand;
            o_gnt      = NUM_REQ'(1) << w_cand;
            o_next_ptr = PW'((int'(w_cand) + 1) % NUM_REQ);
         end
      end
   end

endmodule : fc_rr_arbiter
`default_nettype wire

// File: rtl/fc_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fc_mac_scheduler
// Purpose  : Shares one serial fully-connected MAC between NUM_REQ cores.
//            Round-robin grants a core, freezes its N_IN-element vector,
//            performs one MAC per cycle against the weight registers, adds
//            the bias and returns the result with a one-cycle strobe.
//            Also holds the weight/bias configuration registers.
// Config   : FC_SAT_EN - when defined, every accumulate step and the bias
//            add saturate to the signed ACC_W range; otherwise they wrap.
// Ports    : clk, rst   - clock, synchronous active-high reset
//            req        - per-core request, held until gnt
//            req_data   - flattened vectors, core k elem i at (k*N_IN+i)*DW
//            gnt        - one-hot grant pulse
//            rsp_valid  - one-hot result strobe
//            rsp_data   - result, valid with rsp_valid
//            busy       - high while a job is in MAC or DONE
//            cfg_we/cfg_addr/cfg_wdata - weight (0..N_IN-1) / bias (N_IN)
// Limits   : DW <= 32, ACC_W <= 64.
// Revision : 1.0 - initial release
// ============================================================================
module fc_mac_scheduler
   import fc_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int N_IN    = FC_N_IN,
   parameter int DW      = 32,
   parameter int ACC_W   = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*N_IN*DW-1:0]   req_data,
   output logic [NUM_REQ-1:0]           gnt,
   output logic [NUM_REQ-1:0]           rsp_valid,
   output logic [ACC_W-1:0]             rsp_data,
   output logic                         busy,
   input  logic                         cfg_we,
   input  logic [$clog2(N_IN+1)-1:0]    cfg_addr,
   input  logic [DW-1:0]                cfg_wdata
);

   localparam int c_PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int c_IW = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int c_AW = $clog2(N_IN + 1);
   localparam logic [c_AW-1:0] c_BIAS_ADDR = c_AW'(N_IN);
   localparam logic [c_IW-1:0] c_LAST_IDX  = c_IW'(N_IN - 1);
`ifdef FC_SAT_EN
   localparam bit c_SAT = 1'b1;
`else
   localparam bit c_SAT = 1'b0;
`endif

   fc_state_t                r_state, w_state_nxt;
   logic [NUM_REQ-1:0]       r_gnt, w_gnt_nxt;
   logic [NUM_REQ-1:0]       r_rsp_valid, w_rsp_valid_nxt;
   logic [ACC_W-1:0]         r_rsp_data, w_rsp_data_nxt;
   logic                     r_busy, w_busy_nxt;
   logic [c_PW-1:0]          r_ptr, w_ptr_nxt;
   logic [c_PW-1:0]          r_core, w_core_nxt;
   logic [c_IW-1:0]          r_idx, w_idx_nxt;
   logic signed [ACC_W-1:0]  r_acc, w_acc_nxt;
   logic [N_IN*DW-1:0]       r_x, w_x_nxt;
   logic signed [DW-1:0]     r_w [N_IN];
   logic signed [DW-1:0]     r_bias;

   logic                     w_arb_any;
   logic [NUM_REQ-1:0]       w_arb_gnt;
   logic [c_PW-1:0]          w_arb_sel;
   logic [c_PW-1:0]          w_arb_next;
   logic                     w_cfg_wr;
   logic signed [DW-1:0]     w_x_cur;
   logic signed [2*DW-1:0]   w_prod;
   logic signed [ACC_W-1:0]  w_mac_sum;
   logic signed [ACC_W-1:0]  w_bias_sum;

   fc_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PW      (c_PW)
   ) u_arb (
      .i_req      (req),
      .i_ptr      (r_ptr),
      .o_any      (w_arb_any),
      .o_gnt      (w_arb_gnt),
      .o_sel      (w_arb_sel),
      .o_next_ptr (w_arb_next)
   );

   // Config only lands while idle; a write on a grant edge is visible to
   // that job because MAC reads the weights from the following edge on.
   assign w_cfg_wr = cfg_we && (r_state == IDLE);

   for (genvar i = 0; i < N_IN; i++) begin : g_wgt
      always_ff @(posedge clk) begin
         if (rst) begin
            r_w[i] <= DW'(1);
         end else if (w_cfg_wr && (cfg_addr == c_AW'(i))) begin
            r_w[i] <= cfg_wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bias <= '0;
      end else if (w_cfg_wr && (cfg_addr == c_BIAS_ADDR)) begin
         r_bias <= cfg_wdata;
      end
   end

   // Full-width product; truncation or saturation happens in fc_accum.
   assign w_x_cur    = r_x[int'(r_idx)*DW +: DW];
   assign w_prod     = (2*DW)'(w_x_cur) * (2*DW)'(r_w[r_idx]);
   assign w_mac_sum  = ACC_W'(fc_accum(64'(r_acc), 64'(w_prod), ACC_W, c_SAT));
   assign w_bias_sum = ACC_W'(fc_accum(64'(r_acc), 64'(r_bias), ACC_W, c_SAT));

   always_comb begin
      w_state_nxt     = r_state;
      w_gnt_nxt       = '0;
      w_rsp_valid_nxt = '0;
      w_rsp_data_nxt  = r_rsp_data;
      w_busy_nxt      = r_busy;
      w_ptr_nxt       = r_ptr;
      w_core_nxt      = r_core;
      w_idx_nxt       = r_idx;
      w_acc_nxt       = r_acc;
      w_x_nxt         = r_x;
      case (r_state)
         IDLE: begin
            if (w_arb_any) begin
               w_gnt_nxt   = w_arb_gnt;
               w_x_nxt     = req_data[int'(w_arb_sel)*N_IN*DW +: N_IN*DW];
               w_acc_nxt   = '0;
               w_idx_nxt   = '0;
               w_ptr_nxt   = w_arb_next;
               w_core_nxt  = w_arb_sel;
               w_busy_nxt  = 1'b1;
               w_state_nxt = MAC;
            end
         end
         MAC: begin
            w_acc_nxt = w_mac_sum;
            w_idx_nxt = r_idx + c_IW'(1);
            if (r_idx == c_LAST_IDX) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_rsp_data_nxt  = w_bias_sum;
            w_rsp_valid_nxt = NUM_REQ'(1) << r_core;
            w_busy_nxt      = 1'b0;
            w_state_nxt     = IDLE;
         end
         default: begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_gnt       <= '0;
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
         r_busy      <= 1'b0;
         r_ptr       <= '0;
         r_core      <= '0;
         r_idx       <= '0;
         r_acc       <= '0;
         r_x         <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_gnt       <= w_gnt_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_data  <= w_rsp_data_nxt;
         r_busy      <= w_busy_nxt;
         r_ptr       <= w_ptr_nxt;
         r_core      <= w_core_nxt;
         r_idx       <= w_idx_nxt;
         r_acc       <= w_acc_nxt;
         r_x         <= w_x_nxt;
      end
   end

   assign gnt       = r_gnt;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign busy      = r_busy;

endmodule : fc_mac_scheduler
`default_nettype wire

// File: tb/tb_fc_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_mac_scheduler
// Purpose  : Self-checking bench for fc_mac_scheduler. Expected results are
//            computed from a bench-side weight/bias model and queued when a
//            job is launched; a monitor pops and compares on rsp_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fc_mac_scheduler;

   localparam int NUM_REQ = 4;
   localparam int N_IN    = 9;
   localparam int DW      = 32;
   localparam int ACC_W   = 32;

   typedef struct {
      int          core;
      logic [31:0] data;
   } exp_t;

   logic                       clk = 1'b0;
   logic                       rst;
   logic [NUM_REQ-1:0]         req;
   logic [NUM_REQ*N_IN*DW-1:0] req_data;
   logic [NUM_REQ-1:0]         gnt;
   logic [NUM_REQ-1:0]         rsp_valid;
   logic [ACC_W-1:0]           rsp_data;
   logic                       busy;
   logic                       cfg_we;
   logic [3:0]                 cfg_addr;
   logic [DW-1:0]              cfg_wdata;

   int          n_total = 0;
   int          n_bad   = 0;
   int          cyc     = 0;
   int          n_rsp   = 0;
   int          rsp_cyc = 0;
   logic [31:0] last_rsp = '0;
   exp_t        sb_q[$];

   int xv [NUM_REQ][N_IN];
   int tw [N_IN];
   int tbias;

   fc_mac_scheduler #(
      .NUM_REQ (NUM_REQ),
      .N_IN    (N_IN),
      .DW      (DW),
      .ACC_W   (ACC_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_data  (req_data),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .busy      (busy),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic longint step(input longint v);
`ifdef FC_SAT_EN
      if (v > 64'sd2147483647) return 64'sd2147483647;
      if (v < -64'sd2147483648) return -64'sd2147483648;
      return v;
`else
      return longint'(int'(v));
`endif
   endfunction

   function automatic logic [31:0] model(input int core);
      longint acc;
      acc = 0;
      for (int i = 0; i < N_IN; i++) begin
         acc = step(acc + longint'(xv[core][i]) * longint'(tw[i]));
      end
      acc = step(acc + longint'(tbias));
      return acc[31:0];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N_IN; i++) tw[i] = 1;
      tbias = 0;
   endtask

   task automatic drive_data();
      for (int k = 0; k < NUM_REQ; k++)
         for (int i = 0; i < N_IN; i++)
            req_data[(k*N_IN+i)*DW +: DW] = xv[k][i];
   endtask

   task automatic push(input int core);
      exp_t e;
      e.core = core;
      e.data = model(core);
      sb_q.push_back(e);
   endtask

   task automatic cfg(input int addr, input int data, input bit lands);
      cfg_we    = 1'b1;
      cfg_addr  = 4'(addr);
      cfg_wdata = data;
      @(negedge clk);
      cfg_we = 1'b0;
      if (lands) begin
         if (addr < N_IN) tw[addr] = data;
         else if (addr == N_IN) tbias = data;
      end
   endtask

   task automatic wait_gnt(output int core, output int at);
      core = -1;
      at   = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (gnt != 0) begin
            for (int k = 0; k < NUM_REQ; k++) if (gnt[k]) core = k;
            at = cyc;
            break;
         end
      end
      if (core < 0) chk("gnt_timeout", 0, 1);
   endtask

   task automatic drain();
      for (int c = 0; c < 300; c++) begin
         if (sb_q.size() == 0 && !busy) return;
         @(negedge clk);
      end
      chk("drain_timeout", 64'(sb_q.size()), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!rst && rsp_valid != 0) begin
         n_rsp    <= n_rsp + 1;
         rsp_cyc  <= cyc;
         last_rsp <= rsp_data;
         if (sb_q.size() == 0) begin
            chk("spurious_rsp", 64'(rsp_valid), 0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("rsp_core", 64'(rsp_valid), 64'(1) << e.core);
            chk("rsp_data", 64'(rsp_data), 64'(e.data));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, t0, tp, bcnt, gcnt, snap;
      int order [5];
      order = '{0, 1, 2, 3, 0};
      rst = 1'b1; req = '0; req_data = '0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      for (int c = 0; c < NUM_REQ; c++) for (int i = 0; i < N_IN; i++) xv[c][i] = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      chk("rst_gnt", 64'(gnt), 0);
      chk("rst_rsp_valid", 64'(rsp_valid), 0);
      chk("rst_rsp_data", 64'(rsp_data), 0);
      chk("rst_busy", 64'(busy), 0);

      // Single request, default weights; vector frozen at grant
      for (int i = 0; i < N_IN; i++) xv[0][i] = i + 1;
      drive_data(); push(0); req = 4'b0001;
      wait_gnt(k, t0);
      req = '0;
      chk("t1_gnt", 64'(gnt), 1);
      for (int i = 0; i < N_IN; i++) xv[0][i] = 99;
      drive_data();
      bcnt = busy ? 1 : 0; gcnt = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (busy) bcnt++;
         if (gnt != 0) gcnt++;
      end
      chk("t1_busy_cycles", 64'(bcnt), 10);
      chk("t1_gnt_once", 64'(gcnt), 0);
      chk("t1_latency", 64'(rsp_cyc - t0), 10);
      drain();
      chk("t1_result", 64'(last_rsp), 45);

      // Programmed weights and negative bias, core 2
      for (int i = 0; i < N_IN; i++) cfg(i, i, 1'b1);
      cfg(N_IN, -5, 1'b1);
      for (int i = 0; i < N_IN; i++) xv[2][i] = 2;
      drive_data(); push(2); req = 4'b0100;
      wait_gnt(k, t0);
      req = '0;
      chk("t2_gnt", 64'(k), 2);
      drain();
      chk("t2_result", 64'(last_rsp), 67);

      // Round-robin fairness with all requests held
      do_reset();
      for (int c = 0; c < NUM_REQ; c++) for (int i = 0; i < N_IN; i++) xv[c][i] = c * 10 + i;
      drive_data();
      for (int n = 0; n < 5; n++) push(order[n]);
      req = 4'hF;
      tp = 0;
      for (int n = 0; n < 5; n++) begin
         wait_gnt(k, t0);
         chk("rr_order", 64'(k), 64'(order[n]));
         if (n > 0) chk("rr_spacing", 64'(t0 - tp), 11);
         tp = t0;
      end
      req = '0;
      drain();

      // Config write while busy is dropped; same write in idle lands
      for (int i = 0; i < N_IN; i++) xv[0][i] = i + 1;
      drive_data(); push(0); req = 4'b0001;
      wait_gnt(k, t0);
      req = '0;
      repeat (3) @(negedge clk);
      cfg(N_IN, 100, 1'b0);
      drain();
      chk("t4_busy_write", 64'(last_rsp), 45);
      cfg(N_IN, 100, 1'b1);
      cfg(10, 999, 1'b1);
      push(0); req = 4'b0001;
      wait_gnt(k, t0);
      req = '0;
      drain();
      chk("t4_idle_write", 64'(last_rsp), 145);

      // Reset in the middle of a job
      for (int i = 0; i < N_IN; i++) xv[3][i] = 7;
      drive_data(); req = 4'b1000;
      wait_gnt(k, t0);
      req = '0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      chk("t5_busy", 64'(busy), 0);
      chk("t5_gnt", 64'(gnt), 0);
      snap = n_rsp;
      repeat (15) @(negedge clk);
      chk("t5_no_rsp", 64'(n_rsp), 64'(snap));
      for (int i = 0; i < N_IN; i++) begin xv[0][i] = 3 * i; xv[1][i] = 5; end
      drive_data(); push(0); push(1); req = 4'b0011;
      wait_gnt(k, t0);
      req = 4'b0010;
      chk("t5_gnt_core0", 64'(k), 0);
      wait_gnt(k, t0);
      req = '0;
      chk("t5_gnt_core1", 64'(k), 1);
      drain();

      // Overflow, with the weight write on the grant edge itself
      for (int i = 0; i < N_IN; i++) xv[0][i] = 0;
      xv[0][0] = 32'h7FFFFFFF;
      drive_data();
      cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 32'd2; tw[0] = 2;
      push(0); req = 4'b0001;
      wait_gnt(k, t0);
      cfg_we = 1'b0; req = '0;
      chk("t6_gnt", 64'(k), 0);
      drain();
`ifdef FC_SAT_EN
      chk("t6_overflow", 64'(last_rsp), 64'h7FFFFFFF);
`else
      chk("t6_overflow", 64'(last_rsp), 64'hFFFFFFFE);
`endif
      chk("sb_empty", 64'(sb_q.size()), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_fc_mac_scheduler
`default_nettype wire
